// File: rtl/haar_pkg.sv
// -----------------------------------------------------------------------------
// haar_pkg
// Shared types and constants for the face-detection candidate reporting path.
//   coord_t    : 12-bit unsigned coordinate / frame dimension
//   det_rec_t  : detection record {x, y, size} in source-frame pixels
//   SAT_MAX    : saturation value for back-projected results
//   state_e    : candidate_reporter FSM state encoding
// -----------------------------------------------------------------------------
package haar_pkg;

  localparam int COORD_W = 12;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    coord_t size;
  } det_rec_t;

  localparam coord_t SAT_MAX = 12'hFFF;

  // Explicit values keep the encoding stable for anything that decodes it
  // from a debug bus.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DIV_X = 3'd2,
    ST_DIV_Y = 3'd3,
    ST_DIV_S = 3'd4,
    ST_OUT   = 3'd5
  } state_e;

endpackage

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Unsigned restoring divider, one quotient bit per clock.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   start_i       : load dividend/divisor and begin (ignored while busy only
//                   in the sense that a new start restarts the operation)
//   dividend_i    : 24-bit unsigned dividend
//   divisor_i     : 12-bit unsigned divisor
//   done_o        : high during the final iteration cycle; quotient_o is
//                   valid in that same cycle
//   quotient_o    : 12-bit quotient, saturated to SAT_MAX on overflow or on
//                   a zero divisor
// DIV_CYCLES must equal the dividend width.
// -----------------------------------------------------------------------------
module seq_divider
  import haar_pkg::*;
#(
  parameter int DIV_CYCLES = 2 * COORD_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [2*COORD_W-1:0] dividend_i,
  input  coord_t               divisor_i,
  output logic                 done_o,
  output coord_t               quotient_o
);

  localparam int DW    = 2 * COORD_W;
  localparam int CNT_W = $clog2(DIV_CYCLES + 1);

  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DW-1:0]    dq_q;       // dividend shifts out the top, quotient in at the bottom
  coord_t           rem_q;
  coord_t           divisor_q;
  logic             dz_q;

  logic [COORD_W:0] rem_sh;
  logic [COORD_W:0] rem_diff;
  logic             ge;
  logic [DW-1:0]    dq_d;

  always_comb begin
    rem_sh   = {rem_q, dq_q[DW-1]};
    rem_diff = rem_sh - {1'b0, divisor_q};
    // rem_sh < 2*divisor, so a non-negative difference always fits in
    // COORD_W bits and the top bit acts as the borrow.
    ge       = ~rem_diff[COORD_W];
    dq_d     = {dq_q[DW-2:0], ge};
  end

  assign done_o     = busy_q && (cnt_q == CNT_W'(1));
  assign quotient_o = (dz_q || (|dq_d[DW-1:COORD_W])) ? SAT_MAX : dq_d[COORD_W-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      dq_q      <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      dz_q      <= 1'b0;
    end else if (start_i) begin
      busy_q    <= 1'b1;
      cnt_q     <= CNT_W'(DIV_CYCLES);
      dq_q      <= dividend_i;
      rem_q     <= '0;
      divisor_q <= divisor_i;
      dz_q      <= (divisor_i == '0);
    end else if (busy_q) begin
      dq_q  <= dq_d;
      rem_q <= ge ? rem_diff[COORD_W-1:0] : rem_sh[COORD_W-1:0];
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/candidate_reporter.sv
// -----------------------------------------------------------------------------
// candidate_reporter
// Buffers cascade-classifier candidates, back-projects each window from the
// scaled frame to the source frame and emits one record per candidate.
//   clk_fpga, reset_fpga           : clock, synchronous active-high reset
//   candidate, scale_x/ycoord      : candidate pulse and scaled-frame position
//   frame_src/dst_width/height     : frame dimensions, sampled in LOAD only
//   det_valid/det_ready            : record handshake
//   det_x, det_y, det_size         : source-frame record fields
//   overflow, drop_count           : sticky drop flag, saturating drop count
//
// state  | meaning
// IDLE   | waiting; pops the FIFO head when non-empty
// LOAD   | latch frame dimensions for the popped candidate
// DIV_X  | x * src_w / dst_w      (issue cycle + DIV_CYCLES)
// DIV_Y  | y * src_h / dst_h      (issue cycle + DIV_CYCLES)
// DIV_S  | WINDOW * src_w / dst_w (issue cycle + DIV_CYCLES), then register
// OUT    | record presented until det_ready
// -----------------------------------------------------------------------------
module candidate_reporter
  import haar_pkg::*;
#(
  parameter int DATA_WIDTH_12 = COORD_W,
  parameter int WINDOW_SIZE   = 24,
  parameter int FIFO_DEPTH    = 4,
  parameter int DIV_CYCLES    = 2 * DATA_WIDTH_12
) (
  input  logic                     clk_fpga,
  input  logic                     reset_fpga,
  input  logic                     candidate,
  input  logic [DATA_WIDTH_12-1:0] scale_xcoord,
  input  logic [DATA_WIDTH_12-1:0] scale_ycoord,
  input  logic [DATA_WIDTH_12-1:0] frame_src_width,
  input  logic [DATA_WIDTH_12-1:0] frame_src_height,
  input  logic [DATA_WIDTH_12-1:0] frame_dst_width,
  input  logic [DATA_WIDTH_12-1:0] frame_dst_height,
  output logic                     det_valid,
  input  logic                     det_ready,
  output logic [DATA_WIDTH_12-1:0] det_x,
  output logic [DATA_WIDTH_12-1:0] det_y,
  output logic [DATA_WIDTH_12-1:0] det_size,
  output logic                     overflow,
  output logic [7:0]               drop_count
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CTW = PW + 1;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } cand_t;

  // Candidate FIFO
  cand_t          fifo_q [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CTW-1:0] count_q, count_d;
  logic           full, pop, push, drop;

  // FSM and datapath
  state_e         state_q;
  logic           issued_q;
  cand_t          cand_q;
  coord_t         src_w_q, src_h_q, dst_w_q, dst_h_q;
  coord_t         res_x_q, res_y_q;
  det_rec_t       det_q;
  logic           det_valid_q;
  logic           overflow_q;
  logic [7:0]     drop_cnt_q;

  // Divider interface
  coord_t            div_a, div_b, div_den;
  logic [2*COORD_W-1:0] div_dividend;
  logic              div_start, div_done;
  coord_t            div_quot;

  assign full = (count_q == CTW'(FIFO_DEPTH));
  assign pop  = (state_q == ST_IDLE) && (count_q != '0);
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push = candidate && (!full || pop);
  assign drop = candidate && full && !pop;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CTW'(1);
      2'b01:   count_d = count_q - CTW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_fpga) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= '{x: scale_xcoord, y: scale_ycoord};
    end
  end

  always_ff @(posedge clk_fpga) begin
    if (reset_fpga) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    div_a   = cand_q.x;
    div_b   = src_w_q;
    div_den = dst_w_q;
    case (state_q)
      ST_DIV_Y: begin
        div_a   = cand_q.y;
        div_b   = src_h_q;
        div_den = dst_h_q;
      end
      ST_DIV_S: begin
        div_a   = coord_t'(WINDOW_SIZE);
        div_b   = src_w_q;
        div_den = dst_w_q;
      end
      default: ;
    endcase
    div_dividend = {{COORD_W{1'b0}}, div_a} * {{COORD_W{1'b0}}, div_b};
  end

  // First cycle of each DIV_* state issues the operands to the divider.
  assign div_start = ((state_q == ST_DIV_X) || (state_q == ST_DIV_Y) ||
                      (state_q == ST_DIV_S)) && !issued_q;

  seq_divider #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div (
    .clk_i     (clk_fpga),
    .rst_i     (reset_fpga),
    .start_i   (div_start),
    .dividend_i(div_dividend),
    .divisor_i (div_den),
    .done_o    (div_done),
    .quotient_o(div_quot)
  );

  always_ff @(posedge clk_fpga) begin
    if (reset_fpga) begin
      state_q     <= ST_IDLE;
      issued_q    <= 1'b0;
      cand_q      <= '0;
      src_w_q     <= '0;
      src_h_q     <= '0;
      dst_w_q     <= '0;
      dst_h_q     <= '0;
      res_x_q     <= '0;
      res_y_q     <= '0;
      det_q       <= '0;
      det_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            cand_q  <= fifo_q[rd_ptr_q];
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          src_w_q  <= frame_src_width;
          src_h_q  <= frame_src_height;
          dst_w_q  <= frame_dst_width;
          dst_h_q  <= frame_dst_height;
          issued_q <= 1'b0;
          state_q  <= ST_DIV_X;
        end
        ST_DIV_X: begin
          if (!issued_q) begin
            issued_q <= 1'b1;
          end else if (div_done) begin
            res_x_q  <= div_quot;
            issued_q <= 1'b0;
            state_q  <= ST_DIV_Y;
          end
        end
        ST_DIV_Y: begin
          if (!issued_q) begin
            issued_q <= 1'b1;
          end else if (div_done) begin
            res_y_q  <= div_quot;
            issued_q <= 1'b0;
            state_q  <= ST_DIV_S;
          end
        end
        ST_DIV_S: begin
          if (!issued_q) begin
            issued_q <= 1'b1;
          end else if (div_done) begin
            det_q       <= '{x: res_x_q, y: res_y_q, size: div_quot};
            det_valid_q <= 1'b1;
            issued_q    <= 1'b0;
            state_q     <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (det_ready) begin
            det_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign det_valid  = det_valid_q;
  assign det_x      = det_q.x;
  assign det_y      = det_q.y;
  assign det_size   = det_q.size;
  assign overflow   = overflow_q;
  assign drop_count = drop_cnt_q;

endmodule
